// File: rtl/cmp_nbit_seq.sv
// cmp_nbit_seq: multi-cycle magnitude comparator.
// Walks two WIDTH-bit operands CHUNK bits per cycle, most significant chunk
// first, and finishes at the first chunk that differs. Signed operands are
// turned into offset binary when they are latched, so a single unsigned
// chunk comparator serves both modes. Results are registered and hold
// their values until the next completion.
module cmp_nbit_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             ahigher,
  output logic             alower,
  output logic             asame
);

  localparam int NCHUNK = WIDTH / CHUNK;
  // The chunk counter keeps at least one bit so NCHUNK=1 still has a legal vector.
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_reg,   state_next;
  logic [WIDTH-1:0] sa_reg,      sa_next;
  logic [WIDTH-1:0] sb_reg,      sb_next;
  logic [CW-1:0]    cnt_reg,     cnt_next;
  logic             busy_reg,    busy_next;
  logic             done_reg,    done_next;
  logic             ahigher_reg, ahigher_next;
  logic             alower_reg,  alower_next;
  logic             asame_reg,   asame_next;

  // Operands as they enter the shift registers (MSB flipped in signed mode).
  logic [WIDTH-1:0] a_cond;
  logic [WIDTH-1:0] b_cond;

  // Chunk currently under comparison and its verdict.
  logic [CHUNK-1:0] sa_top;
  logic [CHUNK-1:0] sb_top;
  logic             top_gt;
  logic             top_eq;
  logic             last_chunk;

  // Flipping the sign bit maps two's complement onto offset binary, which
  // orders correctly under an unsigned compare.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cond
      if (gi == WIDTH - 1) begin : g_msb
        assign a_cond[gi] = a[gi] ^ signed_mode;
        assign b_cond[gi] = b[gi] ^ signed_mode;
      end else begin : g_low
        assign a_cond[gi] = a[gi];
        assign b_cond[gi] = b[gi];
      end
    end
  endgenerate

  assign sa_top     = sa_reg[WIDTH-1 -: CHUNK];
  assign sb_top     = sb_reg[WIDTH-1 -: CHUNK];
  assign top_gt     = (sa_top > sb_top);
  assign top_eq     = (sa_top == sb_top);
  assign last_chunk = (cnt_reg == LAST_CHUNK);

  // Next-state logic: accept in IDLE, then scan one chunk per cycle in RUN.
  always_comb begin
    state_next   = state_reg;
    sa_next      = sa_reg;
    sb_next      = sb_reg;
    cnt_next     = cnt_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    ahigher_next = ahigher_reg;
    alower_next  = alower_reg;
    asame_next   = asame_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          sa_next    = a_cond;
          sb_next    = b_cond;
          cnt_next   = '0;
          busy_next  = 1'b1;
          state_next = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!top_eq) begin
          // First differing chunk decides the whole compare.
          ahigher_next = top_gt;
          alower_next  = !top_gt;
          asame_next   = 1'b0;
          done_next    = 1'b1;
          busy_next    = 1'b0;
          state_next   = ST_IDLE;
        end else if (last_chunk) begin
          ahigher_next = 1'b0;
          alower_next  = 1'b0;
          asame_next   = 1'b1;
          done_next    = 1'b1;
          busy_next    = 1'b0;
          state_next   = ST_IDLE;
        end else begin
          // Bring the next lower chunk up to the compare position.
          sa_next  = sa_reg << CHUNK;
          sb_next  = sb_reg << CHUNK;
          cnt_next = cnt_reg + CW'(1);
        end
      end

      default: begin
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any compare and clears results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      sa_reg      <= '0;
      sb_reg      <= '0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      ahigher_reg <= 1'b0;
      alower_reg  <= 1'b0;
      asame_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sa_reg      <= sa_next;
      sb_reg      <= sb_next;
      cnt_reg     <= cnt_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      ahigher_reg <= ahigher_next;
      alower_reg  <= alower_next;
      asame_reg   <= asame_next;
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign ahigher = ahigher_reg;
  assign alower  = alower_reg;
  assign asame   = asame_reg;

endmodule

// File: tb/tb_cmp_nbit_seq.sv
// tb_cmp_nbit_seq: scoreboard bench for cmp_nbit_seq.
// Three instances (8/4, 32/4, 8/8) share operand and reset lines and each
// has its own start. Expected results and completion edges are pushed when
// a start is predicted to be accepted and popped when a done pulse appears.
module tb_cmp_nbit_seq;

  localparam int W_T[3] = '{8, 32, 8};
  localparam int C_T[3] = '{4, 4, 8};

  typedef struct {
    int         inst;
    logic [2:0] res;    // {ahigher, alower, asame}
    int         k;      // index of first differing chunk
    int         edge_n; // edge after which done must be high
  } ent_t;

  logic        clk;
  logic        rst;
  logic [2:0]  start_v;
  logic        sm_drv;
  logic [31:0] a_drv;
  logic [31:0] b_drv;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [2:0]  hi_v;
  logic [2:0]  lo_v;
  logic [2:0]  eq_v;

  ent_t sb[$];
  int   cyc       = 0;
  int   free_edge = 0;
  int   bcnt[3]   = '{0, 0, 0};
  int   n_cmp     = 0;
  int   n_bad     = 0;

  cmp_nbit_seq #(.WIDTH(8), .CHUNK(4)) u_w8c4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .signed_mode(sm_drv),
    .a(a_drv[7:0]), .b(b_drv[7:0]), .busy(busy_v[0]), .done(done_v[0]),
    .ahigher(hi_v[0]), .alower(lo_v[0]), .asame(eq_v[0])
  );

  cmp_nbit_seq #(.WIDTH(32), .CHUNK(4)) u_w32c4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .signed_mode(sm_drv),
    .a(a_drv), .b(b_drv), .busy(busy_v[1]), .done(done_v[1]),
    .ahigher(hi_v[1]), .alower(lo_v[1]), .asame(eq_v[1])
  );

  cmp_nbit_seq #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
    .clk(clk), .rst(rst), .start(start_v[2]), .signed_mode(sm_drv),
    .a(a_drv[7:0]), .b(b_drv[7:0]), .busy(busy_v[2]), .done(done_v[2]),
    .ahigher(hi_v[2]), .alower(lo_v[2]), .asame(eq_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: true signed/unsigned integer compare plus chunk scan for latency.
  function automatic void model(input logic [31:0] a_in, input logic [31:0] b_in,
                                input logic sm, input int w, input int c,
                                output logic [2:0] res, output int k);
    logic [31:0] m, am, bm, cm;
    longint      va, vb;
    int          n;
    bit          found;
    m  = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am = a_in & m;
    bm = b_in & m;
    va = longint'(am);
    vb = longint'(bm);
    if (sm && am[w-1]) va = va - (longint'(1) << w);
    if (sm && bm[w-1]) vb = vb - (longint'(1) << w);
    res = (va > vb) ? 3'b100 : ((va < vb) ? 3'b010 : 3'b001);
    n     = w / c;
    cm    = (c >= 32) ? 32'hFFFF_FFFF : ((32'd1 << c) - 32'd1);
    k     = n - 1;
    found = 0;
    for (int j = 0; j < n; j++) begin
      if (!found && ((((am ^ bm) >> (w - c * (j + 1))) & cm) != 0)) begin
        k     = j;
        found = 1;
      end
    end
  endfunction

  // Monitor: one line per completed transaction, then scoreboard checks.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      sb.delete();
      for (int i = 0; i < 3; i++) bcnt[i] = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (busy_v[i]) bcnt[i]++;
        if (done_v[i]) begin
          if (sb.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
          end else begin
            ent_t e;
            e = sb.pop_front();
            $display("txn inst=%0d edge=%0d res=%b exp=%b k=%0d busy_cycles=%0d",
                     i, cyc, {hi_v[i], lo_v[i], eq_v[i]}, e.res, e.k, bcnt[i]);
            check("inst", i, e.inst);
            check("result", {29'd0, hi_v[i], lo_v[i], eq_v[i]}, {29'd0, e.res});
            check("onehot", $countones({hi_v[i], lo_v[i], eq_v[i]}), 32'd1);
            check("latency", cyc, e.edge_n);
            check("busy_cycles", bcnt[i], e.k + 1);
            check("busy_at_done", {31'd0, busy_v[i]}, 32'd0);
          end
          bcnt[i] = 0;
        end
      end
    end
  end

  // Drive one cycle of stimulus; predicts acceptance from the handshake rules.
  task automatic drive(input int inst, input logic [31:0] a, input logic [31:0] b,
                       input logic sm, input bit go, input bit dir,
                       input logic [2:0] eres, input int ek, output bit acc);
    logic [2:0] r;
    int         k;
    ent_t       e;
    @(negedge clk);
    a_drv   = a;
    b_drv   = b;
    sm_drv  = sm;
    start_v = go ? 3'(1 << inst) : 3'b000;
    acc     = 0;
    if (go && (cyc + 1 >= free_edge)) begin
      model(a, b, sm, W_T[inst], C_T[inst], r, k);
      if (dir) begin
        r = eres;
        k = ek;
      end
      e.inst   = inst;
      e.res    = r;
      e.k      = k;
      e.edge_n = cyc + k + 2;
      sb.push_back(e);
      free_edge = cyc + k + 3;
      acc       = 1;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    start_v = 3'b000;
    while (sb.size() != 0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic gen(input int inst, output logic [31:0] ra, output logic [31:0] rb);
    int          w, c, n, kk, sh;
    logic [31:0] m, lowm, diff;
    w  = W_T[inst];
    c  = C_T[inst];
    n  = w / c;
    m  = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    ra = $urandom & m;
    kk = $urandom_range(0, n);
    if (kk == n) begin
      rb = ra;
    end else begin
      sh   = w - c * (kk + 1);
      diff = 32'($urandom_range(1, (1 << c) - 1)) << sh;
      lowm = (32'd1 << sh) - 32'd1;
      rb   = (((ra ^ diff) & ~lowm) | ($urandom & lowm)) & m;
    end
  endtask

  task automatic run_random(input int inst, input int count);
    int          acc_n, guard;
    logic [31:0] ra, rb;
    bit          acc;
    acc_n = 0;
    guard = 0;
    while (acc_n < count && guard < 20000) begin
      gen(inst, ra, rb);
      drive(inst, ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
            0, 3'b000, 0, acc);
      if (acc) acc_n++;
      guard++;
    end
    check("random_count", acc_n, count);
    wait_idle();
  endtask

  initial begin
    bit acc;
    rst     = 1'b1;
    start_v = 3'b000;
    sm_drv  = 1'b0;
    a_drv   = '0;
    b_drv   = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      check("reset_outs", {27'd0, busy_v[i], done_v[i], hi_v[i], lo_v[i], eq_v[i]}, 32'd0);
    rst = 1'b0;

    // Directed 8/4 cases with hand-derived expectations.
    drive(0, 32'h5A, 32'h3F, 1'b0, 1, 1, 3'b100, 0, acc); wait_idle();
    drive(0, 32'h5A, 32'h5B, 1'b0, 1, 1, 3'b010, 1, acc); wait_idle();
    drive(0, 32'hC3, 32'hC3, 1'b0, 1, 1, 3'b001, 1, acc); wait_idle();
    drive(0, 32'h80, 32'h7F, 1'b1, 1, 1, 3'b010, 0, acc); wait_idle();
    drive(0, 32'h80, 32'h7F, 1'b0, 1, 1, 3'b100, 0, acc); wait_idle();
    drive(0, 32'hFF, 32'h00, 1'b1, 1, 1, 3'b010, 0, acc); wait_idle();
    repeat (3) @(negedge clk);
    check("hold_lo", {31'd0, lo_v[0]}, 32'd1);

    // start held high with changing operands: only predicted accepts complete.
    for (int i = 0; i < 14; i++) begin
      logic [31:0] ra, rb;
      gen(0, ra, rb);
      drive(0, ra, rb, 1'($urandom_range(0, 1)), 1, 0, 3'b000, 0, acc);
    end
    wait_idle();

    // Reset on the second RUN edge of an equal compare aborts it.
    drive(0, 32'h5A, 32'h3F, 1'b0, 1, 1, 3'b100, 0, acc); wait_idle();
    drive(0, 32'h77, 32'h77, 1'b0, 1, 1, 3'b001, 1, acc);
    @(negedge clk);
    start_v = 3'b000;
    check("hold_during_run", {29'd0, hi_v[0], lo_v[0], eq_v[0]}, 32'h4);
    check("busy_in_run", {31'd0, busy_v[0]}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    free_edge = 0;
    check("abort_outs", {27'd0, busy_v[0], done_v[0], hi_v[0], lo_v[0], eq_v[0]}, 32'd0);
    check("abort_queue", sb.size(), 32'd0);
    drive(0, 32'h12, 32'h34, 1'b0, 1, 1, 3'b010, 0, acc); wait_idle();

    // Randomised runs against the reference model.
    run_random(0, 200);
    run_random(1, 1000);
    run_random(2, 1000);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
